// File: rtl/i2c_target.sv
// I2C target with a 16-bit register pointer in front of a small byte-wide register file.
// Every accepted data byte is also exported as a one-cycle write strobe.
`timescale 1ns/1ps

module i2c_target #(
    parameter logic [6:0] I2C_SLAVE_ADDR = 7'h10,
    parameter int         NUM_REGS       = 64
) (
    input  logic        clk,
    input  logic        areset_n,
    input  logic        i2c_scl_i,
    input  logic        i2c_sda_i,
    output logic        i2c_sda_oe,
    output logic        wr_stb,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy
);

    localparam int          IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [15:0] NUM_REGS_W = 16'(NUM_REGS);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_DEV_ADDR  = 4'd1;
    localparam logic [3:0] S_ACK_DEV   = 4'd2;
    localparam logic [3:0] S_ADDR_HI   = 4'd3;
    localparam logic [3:0] S_ACK_HI    = 4'd4;
    localparam logic [3:0] S_ADDR_LO   = 4'd5;
    localparam logic [3:0] S_ACK_LO    = 4'd6;
    localparam logic [3:0] S_WR_DATA   = 4'd7;
    localparam logic [3:0] S_ACK_WR    = 4'd8;
    localparam logic [3:0] S_RD_DATA   = 4'd9;
    localparam logic [3:0] S_RD_ACK    = 4'd10;
    localparam logic [3:0] S_WAIT_STOP = 4'd11;

    logic scl_meta_q, scl_sync_q, scl_hist_q;
    logic sda_meta_q, sda_sync_q, sda_hist_q;

    logic [3:0]  state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        rd_dir_q, rd_dir_d;
    logic        ack_phase_q, ack_phase_d;
    logic [15:0] reg_ptr_q, reg_ptr_d;
    logic        sda_oe_q, sda_oe_d;
    logic        wr_stb_q, wr_stb_d;
    logic [15:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        busy_q, busy_d;

    logic [7:0]       mem_q [NUM_REGS];
    logic             mem_we;
    logic [IDX_W-1:0] mem_idx;
    logic [7:0]       mem_wdata;

    logic        scl_rise, scl_fall, start_det, stop_det;
    logic [7:0]  shift_in, rd_cur, rd_nxt;
    logic [15:0] ptr_inc;

    // Synchronisers idle high so the first cycles after reset never look like a bus edge.
    always_ff @(posedge clk or negedge areset_n) begin
        // NOTE: sequential state is updated with <= so every register samples pre-edge values.
        if (!areset_n) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_hist_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_meta_q <= i2c_scl_i;
            scl_sync_q <= scl_meta_q;
            scl_hist_q <= scl_sync_q;
            sda_meta_q <= i2c_sda_i;
            sda_sync_q <= sda_meta_q;
            sda_hist_q <= sda_sync_q;
        end
    end

    assign scl_rise  = scl_sync_q & ~scl_hist_q;
    assign scl_fall  = ~scl_sync_q & scl_hist_q;
    assign start_det = scl_sync_q & scl_hist_q & sda_hist_q & ~sda_sync_q;
    assign stop_det  = scl_sync_q & scl_hist_q & ~sda_hist_q & sda_sync_q;

    assign shift_in = {shift_q[6:0], sda_sync_q};
    assign ptr_inc  = reg_ptr_q + 16'd1;
    assign rd_cur   = (reg_ptr_q < NUM_REGS_W) ? mem_q[reg_ptr_q[IDX_W-1:0]] : 8'h00;
    assign rd_nxt   = (ptr_inc < NUM_REGS_W) ? mem_q[ptr_inc[IDX_W-1:0]] : 8'h00;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rd_dir_d    = rd_dir_q;
        ack_phase_d = ack_phase_q;
        reg_ptr_d   = reg_ptr_q;
        sda_oe_d    = sda_oe_q;
        wr_stb_d    = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        busy_d      = busy_q;
        mem_we      = 1'b0;
        mem_idx     = reg_ptr_q[IDX_W-1:0];
        mem_wdata   = shift_in;

        if (start_det) begin
            state_d     = S_DEV_ADDR;
            bit_cnt_d   = 3'd0;
            ack_phase_d = 1'b0;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b1;
        end else if (stop_det) begin
            state_d     = S_IDLE;
            bit_cnt_d   = 3'd0;
            ack_phase_d = 1'b0;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b0;
        end else begin
            case (state_q)
                S_DEV_ADDR, S_ADDR_HI, S_ADDR_LO, S_WR_DATA: begin
                    if (scl_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            ack_phase_d = 1'b0;
                            if (state_q == S_DEV_ADDR) begin
                                if (shift_in[7:1] == I2C_SLAVE_ADDR) begin
                                    rd_dir_d = shift_in[0];
                                    state_d  = S_ACK_DEV;
                                end else begin
                                    state_d = S_WAIT_STOP;
                                end
                            end else if (state_q == S_ADDR_HI) begin
                                reg_ptr_d[15:8] = shift_in;
                                state_d         = S_ACK_HI;
                            end else if (state_q == S_ADDR_LO) begin
                                reg_ptr_d[7:0] = shift_in;
                                state_d        = S_ACK_LO;
                            end else begin
                                wr_stb_d  = 1'b1;
                                wr_addr_d = reg_ptr_q;
                                wr_data_d = shift_in;
                                mem_we    = (reg_ptr_q < NUM_REGS_W);
                                reg_ptr_d = ptr_inc;
                                state_d   = S_ACK_WR;
                            end
                        end
                    end
                end
                // Phase 0 waits for the fall ending bit 8, phase 1 for the fall ending the ACK clock.
                S_ACK_DEV, S_ACK_HI, S_ACK_LO, S_ACK_WR: begin
                    if (scl_fall) begin
                        if (!ack_phase_q) begin
                            sda_oe_d    = 1'b1;
                            ack_phase_d = 1'b1;
                        end else begin
                            sda_oe_d    = 1'b0;
                            ack_phase_d = 1'b0;
                            if (state_q == S_ACK_DEV) begin
                                if (rd_dir_q) begin
                                    shift_d  = rd_cur;
                                    sda_oe_d = ~rd_cur[7];
                                    state_d  = S_RD_DATA;
                                end else begin
                                    state_d = S_ADDR_HI;
                                end
                            end else if (state_q == S_ACK_HI) begin
                                state_d = S_ADDR_LO;
                            end else begin
                                state_d = S_WR_DATA;
                            end
                        end
                    end
                end
                S_RD_DATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = S_RD_ACK;
                        end
                    end else if (scl_fall) begin
                        // A zero count means the MSB of a freshly loaded byte is still unsent.
                        if (bit_cnt_q != 3'd0) begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                        end else begin
                            sda_oe_d = ~shift_q[7];
                        end
                    end
                end
                S_RD_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                    end else if (scl_rise) begin
                        reg_ptr_d = ptr_inc;
                        if (!sda_sync_q) begin
                            shift_d = rd_nxt;
                            state_d = S_RD_DATA;
                        end else begin
                            state_d = S_WAIT_STOP;
                        end
                    end
                end
                default: begin
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            rd_dir_q    <= 1'b0;
            ack_phase_q <= 1'b0;
            reg_ptr_q   <= 16'h0000;
            sda_oe_q    <= 1'b0;
            wr_stb_q    <= 1'b0;
            wr_addr_q   <= 16'h0000;
            wr_data_q   <= 8'h00;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rd_dir_q    <= rd_dir_d;
            ack_phase_q <= ack_phase_d;
            reg_ptr_q   <= reg_ptr_d;
            sda_oe_q    <= sda_oe_d;
            wr_stb_q    <= wr_stb_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            busy_q      <= busy_d;
        end
    end

    // NOTE: the register file has no reset; its contents are undefined until written.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_idx] <= mem_wdata;
        end
    end

    assign i2c_sda_oe = sda_oe_q;
    assign wr_stb     = wr_stb_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-banged I2C master drives random transactions, a transaction-level
// model predicts write strobes and read bytes, and monitor processes compare against the DUT.
`timescale 1ns/1ps

module tb_i2c_target;

    localparam int         Q_NS   = 60;
    localparam logic [7:0] ADDR_W = 8'h20;
    localparam logic [7:0] ADDR_R = 8'h21;

    logic        clk      = 1'b0;
    logic        areset_n = 1'b0;
    logic        scl_drv  = 1'b1;
    logic        sda_drv  = 1'b1;
    logic        sda_bus;
    logic        i2c_sda_oe;
    logic        wr_stb;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy;

    always #5 clk = ~clk;

    assign sda_bus = sda_drv & ~i2c_sda_oe;

    i2c_target #(.I2C_SLAVE_ADDR(7'h10), .NUM_REGS(64)) dut (
        .clk        (clk),
        .areset_n   (areset_n),
        .i2c_scl_i  (scl_drv),
        .i2c_sda_i  (sda_bus),
        .i2c_sda_oe (i2c_sda_oe),
        .wr_stb     (wr_stb),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy)
    );

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t         exp_wr [$];
    logic [7:0]  exp_rd [$];
    logic [7:0]  obs_rd [$];
    logic [7:0]  tx_q   [$];
    logic [7:0]  model_mem [64];
    logic [15:0] model_ptr = 16'h0000;
    int          total = 0;
    int          bad   = 0;
    logic        quiet_win = 1'b0;
    logic        oe_seen   = 1'b0;
    wr_t         mon_e;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_rd(input logic [15:0] p);
        return (p < 16'd64) ? model_mem[p[5:0]] : 8'h00;
    endfunction

    // Scoreboard monitor: write strobes and observed read bytes are checked against the queues.
    always @(negedge clk) begin
        if (wr_stb) begin
            check("wr_stb_expected", 32'(exp_wr.size() != 0), 1);
            if (exp_wr.size() != 0) begin
                mon_e = exp_wr.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
                check("wr_data", 32'(wr_data), 32'(mon_e.data));
            end
        end
        if (obs_rd.size() != 0 && exp_rd.size() != 0) begin
            check("rd_data", 32'(obs_rd.pop_front()), 32'(exp_rd.pop_front()));
        end
        if (quiet_win && i2c_sda_oe) oe_seen = 1'b1;
    end

    task automatic i2c_start();
        sda_drv = 1'b1; scl_drv = 1'b1; #(Q_NS);
        sda_drv = 1'b0; #(Q_NS);
        scl_drv = 1'b0; #(Q_NS);
    endtask

    task automatic i2c_rstart();
        sda_drv = 1'b1; #(Q_NS);
        scl_drv = 1'b1; #(Q_NS);
        sda_drv = 1'b0; #(Q_NS);
        scl_drv = 1'b0; #(Q_NS);
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; #(Q_NS);
        scl_drv = 1'b1; #(Q_NS);
        sda_drv = 1'b1; #(2 * Q_NS);
    endtask

    task automatic write_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            sda_drv = b[i]; #(Q_NS);
            scl_drv = 1'b1; #(2 * Q_NS);
            scl_drv = 1'b0; #(Q_NS);
        end
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        write_bits(b, 8);
        sda_drv = 1'b1; #(Q_NS);
        scl_drv = 1'b1; #(Q_NS);
        ack = sda_bus;  #(Q_NS);
        scl_drv = 1'b0; #(Q_NS);
    endtask

    task automatic send_ack(input logic [7:0] b, input string name);
        logic ack;
        write_byte(b, ack);
        check(name, 32'(ack), 0);
    endtask

    task automatic read_byte(input logic nack);
        logic [7:0] b;
        sda_drv = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            #(Q_NS); scl_drv = 1'b1;
            #(Q_NS); b[i] = sda_bus;
            #(Q_NS); scl_drv = 1'b0;
        end
        #(Q_NS); sda_drv = nack;
        #(Q_NS); scl_drv = 1'b1;
        #(2 * Q_NS); scl_drv = 1'b0;
        #(Q_NS); sda_drv = 1'b1;
        obs_rd.push_back(b);
    endtask

    task automatic set_ptr(input logic [15:0] a);
        send_ack(ADDR_W, "ack_dev_wr");
        send_ack(a[15:8], "ack_addr_hi");
        send_ack(a[7:0], "ack_addr_lo");
        model_ptr = a;
    endtask

    task automatic write_frame(input logic [15:0] a);
        logic [7:0] d;
        i2c_start();
        set_ptr(a);
        while (tx_q.size() != 0) begin
            d = tx_q.pop_front();
            exp_wr.push_back(wr_t'{addr: model_ptr, data: d});
            if (model_ptr < 16'd64) model_mem[model_ptr[5:0]] = d;
            send_ack(d, "ack_wdata");
            model_ptr++;
        end
        i2c_stop();
        check("busy_after_write_stop", 32'(busy), 0);
    endtask

    task automatic read_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            exp_rd.push_back(model_rd(model_ptr));
            model_ptr++;
            read_byte(i == n - 1);
        end
    endtask

    task automatic read_frame_at(input logic [15:0] a, input int n);
        i2c_start();
        set_ptr(a);
        i2c_rstart();
        send_ack(ADDR_R, "ack_dev_rd");
        read_bytes(n);
        i2c_stop();
    endtask

    task automatic read_frame_cur(input int n);
        i2c_start();
        send_ack(ADDR_R, "ack_dev_rd_cur");
        read_bytes(n);
        i2c_stop();
    endtask

    initial begin
        logic ack;
        int   waited;

        #3;
        check("rst_sda_oe", 32'(i2c_sda_oe), 0);
        check("rst_wr_stb", 32'(wr_stb), 0);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        check("rst_busy", 32'(busy), 0);
        #20 areset_n = 1'b1;
        #100;

        // Fill the whole register file so every later read has a defined expectation.
        for (int i = 0; i < 64; i++) tx_q.push_back(8'($urandom));
        write_frame(16'h0000);

        tx_q.push_back(8'hAB);
        tx_q.push_back(8'hCD);
        write_frame(16'h0100);

        tx_q.push_back(8'h5A);
        write_frame(16'h0005);
        i2c_start();
        check("busy_after_start", 32'(busy), 1);
        set_ptr(16'h0005);
        i2c_rstart();
        send_ack(ADDR_R, "ack_dev_rd");
        read_bytes(1);
        check("busy_before_stop", 32'(busy), 1);
        i2c_stop();
        check("busy_after_stop", 32'(busy), 0);

        quiet_win = 1'b1;
        oe_seen   = 1'b0;
        i2c_start();
        write_byte(8'h22, ack);
        check("nack_dev_mismatch", 32'(ack), 1);
        write_byte(8'h01, ack);
        check("nack_after_mismatch_1", 32'(ack), 1);
        write_byte(8'h02, ack);
        check("nack_after_mismatch_2", 32'(ack), 1);
        i2c_stop();
        quiet_win = 1'b0;
        check("oe_quiet_mismatch", 32'(oe_seen), 0);
        check("busy_after_mismatch", 32'(busy), 0);

        tx_q.push_back(8'h00);
        write_frame(16'h0000);
        i2c_start();
        set_ptr(16'hFFFF);
        i2c_rstart();
        send_ack(ADDR_R, "ack_dev_rd_wrap");
        read_bytes(2);
        i2c_stop();
        read_frame_cur(1);

        i2c_start();
        set_ptr(16'h0007);
        write_bits(8'($urandom), 4);
        i2c_stop();
        check("busy_after_abort_stop", 32'(busy), 0);
        read_frame_cur(1);

        i2c_start();
        set_ptr(16'h0009);
        write_bits(8'($urandom), 4);
        i2c_rstart();
        send_ack(ADDR_R, "ack_dev_after_abort");
        read_bytes(1);
        i2c_stop();

        repeat (6) begin
            int a, n;
            a = $urandom_range(0, 71);
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
            write_frame(16'(a));
        end
        repeat (8) begin
            int a;
            a = $urandom_range(0, 71);
            read_frame_at(16'(a), $urandom_range(1, 4));
        end
        read_frame_at(16'h0100, 2);

        i2c_start();
        write_bits(ADDR_W, 8);
        sda_drv = 1'b1;
        waited = 0;
        while (!i2c_sda_oe && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("oe_ack_before_reset", 32'(i2c_sda_oe), 1);
        areset_n = 1'b0;
        #1;
        check("reset_sda_oe_async", 32'(i2c_sda_oe), 0);
        check("reset_wr_stb", 32'(wr_stb), 0);
        check("reset_wr_addr", 32'(wr_addr), 0);
        check("reset_wr_data", 32'(wr_data), 0);
        check("reset_busy", 32'(busy), 0);
        scl_drv = 1'b1;
        sda_drv = 1'b1;
        #100 areset_n = 1'b1;
        #100;
        model_ptr = 16'h0000;

        tx_q.push_back(8'($urandom));
        write_frame(16'h0003);
        read_frame_at(16'h0003, 1);

        waited = 0;
        while ((obs_rd.size() != 0 || exp_wr.size() != 0) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("pending_writes", 32'(exp_wr.size()), 0);
        check("pending_read_obs", 32'(obs_rd.size()), 0);
        check("pending_read_exp", 32'(exp_rd.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
